unidade_de_busca: RTL
=====================

Name: unidade_de_busca

Overview:
Program-counter and fetch sequencer that sits directly upstream of unidade_de_controle in the iZero single-cycle core. It holds the PC, drives the instruction-memory address, and selects the next PC from the control unit's pcSource. It applies the multi-cycle stalls the control unit requests: HALT, INSERT (waits for the user's input confirm) and LDK (waits for disk ready). It produces the commit strobe that gates architectural writes.

Parameters:
PC_WIDTH, 32, PC and address width; PC is word-addressed.
IMM_WIDTH, 26, width of the jump/branch immediate target; zero-extended to PC_WIDTH.
RESET_VECTOR, 0, PC value loaded on reset.
BIOS_ENTRY, 0, PC loaded by rstBios (only when BIOS_RESET_EN is defined).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
pcSource  in  2  next-PC select from the control unit: 00 PC+1, 01 jf taken (immediate), 10 jr (register), 11 j/jal (immediate).
isHalt  in  1  current instruction is HALT.
isInsert  in  1  current instruction is IN with manual input enabled.
isDisk  in  1  current instruction is LDK.
inputConfirm  in  1  debounced user confirm button, level.
diskReady  in  1  disk controller has data valid, level.
immTarget  in  IMM_WIDTH  jump/branch target field.
regTarget  in  PC_WIDTH  jr target (register value).
pc  out  PC_WIDTH  current PC; instruction-memory address.
pcPlusOne  out  PC_WIDTH  pc+1 modulo 2^PC_WIDTH; jal link value.
commit  out  1  the current instruction retires this cycle; gates regWrite, memWrite, diskWrite, outWrite and imWrite downstream.
diskReq  out  1  disk access request, held while waiting.
halted  out  1  core halted.
waitingInput  out  1  core waiting on inputConfirm (drives the LCD prompt).

Behaviour:
- All state updates on the rising edge of clock. reset is synchronous and active-high and dominates every other input.
- Reset values:
  - pc = RESET_VECTOR.
  - state = RUN.
  - Confirm edge-detect register = 0.
  - commit = 0 during the reset cycle.
  - diskReq, halted and waitingInput = 0.
- States: RUN, WAIT_IN, WAIT_DISK, HALTED. All outputs are decoded from state combinationally with the inputs; there are no extra output registers.
- RUN, per cycle:
  - isHalt: commit=0, go to HALTED, pc held.
  - else isInsert: commit=0, go to WAIT_IN, pc held.
  - else isDisk: commit=0, diskReq=1, go to WAIT_DISK, pc held.
  - else: commit=1 and pc <= next.
- next PC:
  - pcSource 00: pcPlusOne.
  - pcSource 01 or 11: zero-extended immTarget.
  - pcSource 10: regTarget.
- WAIT_IN:
  - waitingInput=1, pc held.
  - Confirm rise = inputConfirm & ~previous sample. On rise: commit=1 that cycle, pc <= next, go to RUN.
  - A button already held on entry does not count; a fresh 0→1 transition is required.
- WAIT_DISK:
  - diskReq=1, pc held.
  - When diskReady=1: commit=1, pc <= next, go to RUN. diskReq drops with the state change.
  - Minimum latency is 1 cycle. If diskReady is already high on the entry cycle, the instruction still takes 2 cycles total.
- HALTED:
  - halted=1, commit=0, pc held at the HALT address.
  - Only reset leaves this state.
- Boundaries:
  - pc = 2^PC_WIDTH−1 with pcSource 00 wraps to 0.
  - A jr target is used as-is, with no alignment check.
  - Reset during WAIT_IN or WAIT_DISK aborts the access: diskReq=0 in the cycle after reset.
  - isHalt, isInsert and isDisk are mutually exclusive by decode. If more than one is asserted, priority is halt > insert > disk.
- The confirm edge-detect register samples inputConfirm every cycle in every state.

Optional Feature:
BIOS_RESET_EN
- Defined:
  - Adds input port rstBios (1 bit).
  - When rstBios=1 and reset=0: pc <= BIOS_ENTRY, state <= RUN, commit=0. This is synchronous; reset still dominates.
- Undefined:
  - The port is absent and BIOS_ENTRY is unused.

Decomposition:
- Shared package (izero_pkg):
  - PC_SRC_SEQ=2'b00, PC_SRC_JF=2'b01, PC_SRC_JR=2'b10, PC_SRC_JMP=2'b11.
  - Fetch-state encoding: RUN, WAIT_IN, WAIT_DISK, HALTED.
  - Default PC_WIDTH and IMM_WIDTH.
- One natural sub-module: pc_next_mux, the combinational next-PC select plus the +1 incrementer. The FSM, pc register and edge detector stay in unidade_de_busca.

Test Plan:
- reset, then 4 cycles with pcSource=00 → pc = 0,1,2,3; commit=1 from the first post-reset cycle.
- At pc=5:
  - pcSource=11, immTarget=0x40 → pc=0x40 next cycle.
  - pcSource=10, regTarget=0x1234 → pc=0x1234.
  - pcSource=01, immTarget=7 → pc=7.
- isInsert at pc=9 with inputConfirm held high:
  - pc stays 9, waitingInput=1, commit=0 indefinitely.
  - Release, then press → one commit pulse, pc=10, waitingInput=0.
- isDisk at pc=3 with diskReady low for 3 cycles, then high:
  - diskReq=1 for 4 cycles, single commit, pc=4.
  - Then reset mid-wait on a repeat → diskReq=0 and pc=0 next cycle.
- isHalt at pc=0x20:
  - halted=1, pc frozen for 20 cycles regardless of pcSource, inputConfirm and diskReady.
  - Reset → pc=0, halted=0.
  - Wrap check: force pc=0xFFFFFFFF with pcSource=00 → pc=0, pcPlusOne=1.

Source files
------------

// File: rtl/izero_pkg.sv
//==============================================================================
// izero_pkg : shared pcSource codes, fetch-state encoding and default widths
// Revision  : 1.0
//==============================================================================
`default_nettype none

package izero_pkg;

    localparam int DEF_PC_WIDTH  = 32;
    localparam int DEF_IMM_WIDTH = 26;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_JF  = 2'b01;
    localparam logic [1:0] PC_SRC_JR  = 2'b10;
    localparam logic [1:0] PC_SRC_JMP = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_IN   = 2'd1,
        ST_WAIT_DISK = 2'd2,
        ST_HALTED    = 2'd3
    } fetch_state_t;

endpackage : izero_pkg

`default_nettype wire

// File: rtl/unidade_de_busca_pc_next_mux.sv
//==============================================================================
// pc_next_mux : next-PC select and +1 incrementer for unidade_de_busca
// Revision    : 1.0
//==============================================================================
`default_nettype none

module pc_next_mux
    import izero_pkg::*;
#(
    parameter int PC_WIDTH  = DEF_PC_WIDTH,
    parameter int IMM_WIDTH = DEF_IMM_WIDTH
) (
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic [1:0]           pc_source,
    input  logic [IMM_WIDTH-1:0] imm_target,
    input  logic [PC_WIDTH-1:0]  reg_target,
    output logic [PC_WIDTH-1:0]  pc_plus_one,
    output logic [PC_WIDTH-1:0]  pc_next
);

    logic [PC_WIDTH-1:0] imm_ext;

    // Immediate is zero-extended; a field wider than the PC keeps its low bits.
    generate
        if (PC_WIDTH > IMM_WIDTH) begin : g_imm_zext
            assign imm_ext = {{(PC_WIDTH-IMM_WIDTH){1'b0}}, imm_target};
        end else begin : g_imm_trunc
            assign imm_ext = imm_target[PC_WIDTH-1:0];
        end
    endgenerate

    assign pc_plus_one = pc + PC_WIDTH'(1);

    always_comb begin
        pc_next = pc_plus_one;
        case (pc_source)
            PC_SRC_SEQ: pc_next = pc_plus_one;
            PC_SRC_JF:  pc_next = imm_ext;
            PC_SRC_JR:  pc_next = reg_target;
            PC_SRC_JMP: pc_next = imm_ext;
            default:    pc_next = pc_plus_one;
        endcase
    end

endmodule : pc_next_mux

`default_nettype wire

// File: rtl/unidade_de_busca.sv
//==============================================================================
// unidade_de_busca : PC register, fetch stall FSM and commit strobe (iZero core)
// Optional: BIOS_RESET_EN adds rstBios, a synchronous jump to BIOS_ENTRY.
// Revision         : 1.0
//==============================================================================
`default_nettype none

module unidade_de_busca
    import izero_pkg::*;
#(
    parameter int                  PC_WIDTH     = DEF_PC_WIDTH,
    parameter int                  IMM_WIDTH    = DEF_IMM_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0] BIOS_ENTRY   = '0
) (
    input  logic                 clock,
    input  logic                 reset,
`ifdef BIOS_RESET_EN
    input  logic                 rstBios,
`endif
    input  logic [1:0]           pcSource,
    input  logic                 isHalt,
    input  logic                 isInsert,
    input  logic                 isDisk,
    input  logic                 inputConfirm,
    input  logic                 diskReady,
    input  logic [IMM_WIDTH-1:0] immTarget,
    input  logic [PC_WIDTH-1:0]  regTarget,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [PC_WIDTH-1:0]  pcPlusOne,
    output logic                 commit,
    output logic                 diskReq,
    output logic                 halted,
    output logic                 waitingInput
);

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic                confirm_q;
    logic                confirm_rise;
    logic [PC_WIDTH-1:0] pc_next;
    logic                bios_jump;

`ifdef BIOS_RESET_EN
    assign bios_jump = rstBios;
`else
    logic unused_bios_entry;
    assign bios_jump         = 1'b0;
    assign unused_bios_entry = ^BIOS_ENTRY;
`endif

    pc_next_mux #(
        .PC_WIDTH  (PC_WIDTH),
        .IMM_WIDTH (IMM_WIDTH)
    ) u_pc_next_mux (
        .pc          (pc),
        .pc_source   (pcSource),
        .imm_target  (immTarget),
        .reg_target  (regTarget),
        .pc_plus_one (pcPlusOne),
        .pc_next     (pc_next)
    );

    // Only a fresh 0->1 edge releases WAIT_IN; a button held on entry is ignored.
    assign confirm_rise = inputConfirm & ~confirm_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc        <= RESET_VECTOR;
            state     <= ST_RUN;
            confirm_q <= 1'b0;
        end else begin
            confirm_q <= inputConfirm;
            state     <= state_next;
            if (bios_jump) begin
                pc <= BIOS_ENTRY;
            end else if (commit) begin
                pc <= pc_next;
            end
        end
    end

    always_comb begin
        state_next   = state;
        commit       = 1'b0;
        diskReq      = 1'b0;
        halted       = 1'b0;
        waitingInput = 1'b0;

        case (state)
            ST_RUN: begin
                if (isHalt) begin
                    state_next = ST_HALTED;
                end else if (isInsert) begin
                    state_next = ST_WAIT_IN;
                end else if (isDisk) begin
                    diskReq    = 1'b1;
                    state_next = ST_WAIT_DISK;
                end else begin
                    commit = 1'b1;
                end
            end
            ST_WAIT_IN: begin
                waitingInput = 1'b1;
                if (confirm_rise) begin
                    commit     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_WAIT_DISK: begin
                diskReq = 1'b1;
                if (diskReady) begin
                    commit     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        if (reset) begin
            state_next   = ST_RUN;
            commit       = 1'b0;
            diskReq      = 1'b0;
            halted       = 1'b0;
            waitingInput = 1'b0;
        end else if (bios_jump) begin
            state_next = ST_RUN;
            commit     = 1'b0;
        end
    end

endmodule : unidade_de_busca

`default_nettype wire
